siso_xfer_ctrl: RTL and testbench
=================================

// Module: siso_xfer_ctrl
// PURPOSE
//  Sequencer for an external DEPTH-stage serial-in/serial-out shift chain (per-stage dff with shift enable).
//  - Accepts a parallel word over a valid/ready handshake.
//  - Drives the chain shift enable and serial input, LSB first, then flushes DEPTH zero bits.
//  - Reassembles the bits leaving the chain into a parallel word and presents it over a valid/ready handshake.
//  - Sits between a word-level producer/consumer and the bit-serial register chain; used for chain loopback and delay transfers.
// PARAMETERS
//  WIDTH  8  bits per transferred word (>=1)
//  DEPTH  4  number of stages in the attached shift chain (>=1)
// PORTS
//  clk        in   1      rising-edge clock, single domain
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      producer has a word on in_data
//  in_ready   out  1      controller can accept a word (IDLE only)
//  in_data    in   WIDTH  word to transfer
//  sh_pl      out  1      shift enable to every chain stage
//  sh_di      out  1      serial input to chain stage 1
//  sh_do      in   1      serial output of last chain stage
//  out_valid  out  1      out_data holds a completed word
//  out_ready  in   1      consumer accepts out_data
//  out_data   out  WIDTH  reassembled word
//  busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  Reset (sync, highest priority): state=IDLE, cnt=0, tx=0, rx=0.
//  - Outputs after reset: in_ready=1, sh_pl=0, sh_di=0, out_valid=0, out_data=0, busy=0.
//  - The chain shares reset, so the chain is all zeros after reset.
//  FSM states: IDLE, SHIFT, DONE. All outputs are decoded from registered state/data.
//  IDLE:
//  - in_ready=1, sh_pl=0.
//  - On in_valid&&in_ready at an edge: tx<=in_data, cnt<=0, rx<=0, go to SHIFT.
//  SHIFT (lasts exactly WIDTH+DEPTH cycles, cnt=k=0..WIDTH+DEPTH-1):
//  - sh_pl=1.
//  - sh_di=tx[0] while k<WIDTH; sh_di=0 (flush) while k>=WIDTH.
//  - Each edge: tx<=tx>>1, cnt<=cnt+1.
//  - When k>=DEPTH, on that edge: rx<={sh_do, rx[WIDTH-1:1]}. sh_do is the bit injected DEPTH cycles earlier.
//  - At the edge with k==WIDTH+DEPTH-1: go to DONE.
//  DONE:
//  - sh_pl=0, out_valid=1, out_data=rx, held stable until out_ready.
//  - On out_valid&&out_ready: go to IDLE, out_valid falls next cycle.
//  Latency: accept edge -> first sh_pl cycle is the next cycle. out_valid rises WIDTH+DEPTH+1 cycles after the accept edge (13 for defaults).
//  Ideal chain: out_data==in_data, and the chain is all zeros again when DONE is entered.
//  Throughput: one word per WIDTH+DEPTH+2 cycles with out_ready held high; no overlap between words.
//  Boundaries:
//  - in_valid outside IDLE is ignored: in_ready=0, in_data is not sampled.
//  - out_ready low in DONE: stall indefinitely, no chain activity.
//  - out_ready high outside DONE: no effect.
//  - Reset mid-SHIFT or mid-DONE: the word is discarded, no out_valid pulse, sh_pl drops in the cycle after the reset edge.
//  - cnt is $clog2(WIDTH+DEPTH+1) bits wide and never wraps within a transfer.
//  - WIDTH<DEPTH is legal: capture starts after the data bits have been replaced by flush zeros at the chain input.
// TESTING
//  The bench instantiates a behavioural DEPTH-stage chain: dff stages with shared clk, reset and sh_pl.
//  1. Reset held 2 cycles -> all outputs at reset values; in_ready=1; chain outputs 0.
//  2. Loopback, send in_data=8'hA5 with out_ready=1:
//     - sh_di sequence 1,0,1,0,0,1,0,1 then 0,0,0,0.
//     - sh_pl high exactly 12 cycles.
//     - out_valid at +13 cycles with out_data=8'hA5.
//  3. Back-pressure: send 8'h3C, hold out_ready=0 for 20 cycles -> out_valid=1, out_data=8'h3C stable, sh_pl=0, in_ready=0. Then out_ready=1 -> IDLE next cycle.
//  4. Busy rejection: send 8'h0F, then present in_valid with 8'hFF during SHIFT -> in_ready=0; only 8'h0F is returned; the next accept takes a new word only in IDLE.
//  5. Reset mid-transfer: send 8'hFF, assert reset at k=5 -> no out_valid; sh_pl=0 the next cycle; chain all 0. A following transfer of 8'h81 returns 8'h81.
//  6. Back-to-back words 8'h01, 8'h80, 8'h55 with in_valid and out_ready held high -> outputs in order, 14 cycles apart, values exact.

Source files
------------

// File: rtl/siso_xfer_ctrl_if.sv
// Word handshakes plus the serial chain taps of the SISO transfer controller.
// slave is the controller side; master is the producer/consumer/chain side.
interface siso_xfer_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sh_pl;
    logic             sh_di;
    logic             sh_do;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, sh_do, out_ready,
        input  in_ready, sh_pl, sh_di, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, sh_do, out_ready,
        output in_ready, sh_pl, sh_di, out_valid, out_data, busy
    );
endinterface

// File: rtl/siso_xfer_ctrl.sv
// Sequencer for an external DEPTH-stage shift chain: serialises a word LSB first,
// flushes DEPTH zeros and reassembles the bits returning from the chain.
module siso_xfer_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    siso_xfer_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH:0]   rx_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        // Shifting the concatenation keeps the MSB-insert legal even for WIDTH==1.
        rx_shift      = {bus.sh_do, rx_q};
        bus.in_ready  = 1'b0;
        bus.sh_pl     = 1'b0;
        bus.sh_di     = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = rx_q;
        bus.busy      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    tx_d    = bus.in_data;
                    cnt_d   = '0;
                    rx_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.sh_pl = 1'b1;
                bus.busy  = 1'b1;
                bus.sh_di = (cnt_q < WIDTH_C) ? tx_q[0] : 1'b0;
                tx_d      = tx_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                // Chain output carries real data only once the first bit has crossed DEPTH stages.
                if (cnt_q >= DEPTH_C) begin
                    rx_d = rx_shift[WIDTH:1];
                end
                if (cnt_q == LAST_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_siso_xfer_ctrl.sv
// Directed bench: controller driving a behavioural 4-stage shift chain in loopback.
module tb_siso_xfer_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic [DEPTH-1:0] chain;
    int checks;
    int errors;
    int cyc;

    siso_xfer_ctrl_if #(.WIDTH(WIDTH)) xif ();

    siso_xfer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (xif.slave)
    );

    // chain[0] is stage 1, chain[DEPTH-1] the last stage
    always_ff @(posedge clk) begin
        if (reset)          chain <= '0;
        else if (xif.sh_pl) chain <= {chain[DEPTH-2:0], xif.sh_di};
    end
    assign xif.sh_do = chain[DEPTH-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept d, run SHIFT checking the serial stream, then check the returned word.
    task automatic xfer(input string tag, input logic [7:0] d, input logic [11:0] exp_di);
        int pl_cnt;
        pl_cnt = 0;
        xif.out_ready = 1'b1;
        xif.in_data   = d;
        xif.in_valid  = 1'b1;
        chk({tag, "_rdy"}, xif.in_ready, 1'b1);
        tick();
        xif.in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (xif.sh_pl) pl_cnt++;
            chk($sformatf("%s_di%0d", tag, k), xif.sh_di, exp_di[k]);
            tick();
        end
        chk({tag, "_plcnt"}, pl_cnt, 12);
        chk({tag, "_ovalid"}, xif.out_valid, 1'b1);
        chk({tag, "_odata"}, xif.out_data, d);
        chk({tag, "_chain0"}, chain, 4'h0);
        chk({tag, "_pl_done"}, xif.sh_pl, 1'b0);
        tick();
        chk({tag, "_idle"}, xif.in_ready, 1'b1);
        chk({tag, "_ovfall"}, xif.out_valid, 1'b0);
    endtask

    initial begin
        int stable_bad;
        int nseen;
        int acc_cyc;
        int t_out[3];
        logic [7:0] d_out[3];
        logic [7:0] words[3];
        int widx;

        checks = 0;
        errors = 0;
        cyc = 0;
        reset = 1'b1;
        xif.in_valid  = 1'b0;
        xif.in_data   = '0;
        xif.out_ready = 1'b0;

        // 1. reset
        tick();
        tick();
        chk("rst_in_ready", xif.in_ready, 1'b1);
        chk("rst_sh_pl", xif.sh_pl, 1'b0);
        chk("rst_sh_di", xif.sh_di, 1'b0);
        chk("rst_out_valid", xif.out_valid, 1'b0);
        chk("rst_out_data", xif.out_data, 8'h00);
        chk("rst_busy", xif.busy, 1'b0);
        chk("rst_chain", chain, 4'h0);
        reset = 1'b0;
        #1;

        // 2. loopback A5: LSB first 1,0,1,0,0,1,0,1 then four flush zeros
        xfer("lb_a5", 8'hA5, 12'b0000_1010_0101);

        // 3. back-pressure 3C
        xif.out_ready = 1'b0;
        xif.in_data   = 8'h3C;
        xif.in_valid  = 1'b1;
        tick();
        xif.in_valid = 1'b0;
        chk("bp_busy", xif.busy, 1'b1);
        for (int k = 0; k < 12; k++) tick();
        stable_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (xif.out_valid !== 1'b1 || xif.out_data !== 8'h3C || xif.sh_pl !== 1'b0 ||
                xif.in_ready !== 1'b0 || chain !== 4'h0)
                stable_bad++;
            tick();
        end
        chk("bp_stable", stable_bad, 0);
        chk("bp_ovalid", xif.out_valid, 1'b1);
        chk("bp_odata", xif.out_data, 8'h3C);
        xif.out_ready = 1'b1;
        tick();
        chk("bp_release_idle", xif.in_ready, 1'b1);
        chk("bp_release_ov", xif.out_valid, 1'b0);
        chk("bp_release_busy", xif.busy, 1'b0);

        // 4. busy rejection: FF offered during 0F's SHIFT must wait for IDLE
        xif.in_data  = 8'h0F;
        xif.in_valid = 1'b1;
        tick();
        xif.in_valid = 1'b0;
        tick();
        tick();
        xif.in_data  = 8'hFF;
        xif.in_valid = 1'b1;
        chk("rej_in_ready", xif.in_ready, 1'b0);
        for (int k = 2; k < 12; k++) begin
            chk($sformatf("rej_di%0d", k), xif.sh_di, (k < 4) ? 1'b1 : 1'b0);
            tick();
        end
        chk("rej_ovalid", xif.out_valid, 1'b1);
        chk("rej_odata", xif.out_data, 8'h0F);
        tick();
        chk("rej_idle", xif.in_ready, 1'b1);
        tick();
        xif.in_valid = 1'b0;
        chk("rej_next_pl", xif.sh_pl, 1'b1);
        chk("rej_next_di", xif.sh_di, 1'b1);
        for (int k = 0; k < 12; k++) tick();
        chk("rej_next_odata", xif.out_data, 8'hFF);
        chk("rej_next_ov", xif.out_valid, 1'b1);
        tick();

        // 5. reset at k=5 of an FF transfer
        xif.in_data  = 8'hFF;
        xif.in_valid = 1'b1;
        tick();
        xif.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_pl_before", xif.sh_pl, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_pl", xif.sh_pl, 1'b0);
        chk("mid_busy", xif.busy, 1'b0);
        chk("mid_chain", chain, 4'h0);
        chk("mid_odata", xif.out_data, 8'h00);
        nseen = 0;
        for (int k = 0; k < 20; k++) begin
            if (xif.out_valid) nseen++;
            tick();
        end
        chk("mid_no_ovalid", nseen, 0);
        xfer("mid_81", 8'h81, 12'b0000_1000_0001);

        // 6. back-to-back 01, 80, 55
        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'h55;
        widx = 0;
        nseen = 0;
        acc_cyc = 0;
        xif.out_ready = 1'b1;
        xif.in_valid  = 1'b1;
        xif.in_data   = words[0];
        for (int k = 0; k < 80 && nseen < 3; k++) begin
            if (xif.out_valid) begin
                t_out[nseen] = cyc;
                d_out[nseen] = xif.out_data;
                nseen++;
            end
            if (xif.in_valid && xif.in_ready) begin
                tick();
                if (widx == 0) acc_cyc = cyc;
                widx++;
                if (widx < 3) xif.in_data = words[widx];
                else xif.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        xif.in_valid = 1'b0;
        chk("b2b_count", nseen, 3);
        if (nseen == 3) begin
            // out_valid is visible in the 13th cycle after the accept edge
            chk("b2b_latency", t_out[0] - acc_cyc, 12);
            chk("b2b_gap01", t_out[1] - t_out[0], 14);
            chk("b2b_gap12", t_out[2] - t_out[1], 14);
            chk("b2b_d0", d_out[0], 8'h01);
            chk("b2b_d1", d_out[1], 8'h80);
            chk("b2b_d2", d_out[2], 8'h55);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
